// File: rtl/next_pc_predictor.sv
// next_pc_predictor: next-fetch-address generator with a direct-mapped BTB.
// Latency: lookup and redirect are combinational; table updates are visible the cycle after the EX edge.
// Backpressure: none. Updates ignore PC stalls, and a stalled PC simply does not capture npc.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   pc_cur               current PC; lookup is combinational on it
//   npc                  next PC to the program counter (a redirect beats a prediction)
//   pred_taken/target    prediction for pc_cur, carried down the pipeline
//   ex_*                 resolved control instruction from EX; updates the table
//   flush                misprediction; squashes IF/ID and ID/EX
//   mispredict_count     saturating 32-bit count of mispredictions
//
// Build option NPC_2BIT_CTR_EN:
//   defined:   each entry has a 2-bit saturating direction counter.
//   undefined: every hit predicts taken, and a hit conditional branch that
//              resolves not-taken invalidates its entry.
module next_pc_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_cur,
  output logic [63:0] npc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_jump,
  input  logic [63:0] ex_pc,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [63:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 64 - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [63:0]        r_target [ENTRIES];
  logic               r_jump   [ENTRIES];
`ifdef NPC_2BIT_CTR_EN
  logic [1:0]         r_ctr    [ENTRIES];
`endif
  logic [31:0]        r_mis_cnt;

  logic [IDX_W-1:0] w_idx, w_ex_idx;
  logic [TAG_W-1:0] w_tag, w_ex_tag;
  logic             w_hit, w_ex_hit, w_mis;
  logic [63:0]      w_pc_plus4;
  logic             w_unused_ok;

  // The low two PC bits are always zero for aligned instructions and take no part in indexing.
  assign w_unused_ok = ^{pc_cur[1:0], ex_pc[1:0]};

  // Lookup
  assign w_idx      = pc_cur[IDX_W+1:2];
  assign w_tag      = pc_cur[63:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pc_plus4 = pc_cur + 64'd4;

`ifdef NPC_2BIT_CTR_EN
  assign pred_taken = w_hit && (r_jump[w_idx] || r_ctr[w_idx][1]);
`else
  assign pred_taken = w_hit;
`endif
  assign pred_target = w_hit ? r_target[w_idx] : w_pc_plus4;

  // Resolution. While reset is held, the in-flight EX result is discarded,
  // so it raises no flush and no redirect.
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[63:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_mis    = !reset && ex_valid &&
                    ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));

  assign flush            = w_mis;
  assign mispredict_count = r_mis_cnt;

  always_comb begin
    npc = w_pc_plus4;
    if (w_mis)           npc = ex_taken ? ex_target : (ex_pc + 64'd4);
    else if (pred_taken) npc = pred_target;
  end

  // Control state: valid bits, direction counters and the mispredict counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_mis_cnt <= '0;
`ifdef NPC_2BIT_CTR_EN
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
`endif
    end else begin
      if (w_mis && (r_mis_cnt != 32'hFFFF_FFFF)) r_mis_cnt <= r_mis_cnt + 32'd1;
      if (ex_valid) begin
        if (w_ex_hit) begin
`ifdef NPC_2BIT_CTR_EN
          if (ex_is_jump)                              r_ctr[w_ex_idx] <= 2'b11;
          else if (ex_taken && r_ctr[w_ex_idx] != 2'b11)  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          else if (!ex_taken && r_ctr[w_ex_idx] != 2'b00) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
`else
          if (!ex_is_jump && !ex_taken) r_valid[w_ex_idx] <= 1'b0;
`endif
        end else if (ex_taken) begin
          r_valid[w_ex_idx] <= 1'b1;
`ifdef NPC_2BIT_CTR_EN
          r_ctr[w_ex_idx]   <= ex_is_jump ? 2'b11 : 2'b10;
`endif
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed through a set valid bit.
  // A write that lands during reset leaves its valid bit clear, which discards it.
  always_ff @(posedge clk) begin
    if (ex_valid) begin
      if (ex_taken || (w_ex_hit && ex_is_jump)) r_target[w_ex_idx] <= ex_target;
      if (!w_ex_hit && ex_taken) begin
        r_tag[w_ex_idx]  <= w_ex_tag;
        r_jump[w_ex_idx] <= ex_is_jump;
      end
    end
  end

endmodule

// File: doc/next_pc_predictor.md
# next_pc_predictor

Next-PC generator feeding the program counter's `pc_in`. Holds a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters. Each cycle it predicts the next fetch address from the current PC. When the EX stage resolves a control instruction, it updates the table and issues a redirect plus flush on a misprediction.

## Interface
- `ENTRIES`, 16, number of BTB entries; must be a power of two, ≥2. `IDX_W = log2(ENTRIES)`.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `pc_cur` in 64: current PC (program counter output).
- `npc` out 64: next PC to the program counter's `pc_in`.
- `pred_taken` out 1: prediction for `pc_cur`; carried down the pipeline.
- `pred_target` out 64: predicted target for `pc_cur`; carried down the pipeline.
- `ex_valid` in 1: EX holds a resolved branch or jump (0 for bubbles).
- `ex_is_jump` in 1: resolved instruction is JAL/JALR (unconditional).
- `ex_pc` in 64: PC of the resolved instruction.
- `ex_taken` in 1: actual direction.
- `ex_target` in 64: actual taken target.
- `ex_pred_taken` in 1: `pred_taken` carried with the instruction.
- `ex_pred_target` in 64: `pred_target` carried with the instruction.
- `flush` out 1: misprediction; IF/ID and ID/EX must squash.
- `mispredict_count` out 32: saturating count of mispredictions.

## Operation
- Index and tag: `idx = pc[IDX_W+1:2]`, `tag = pc[63:IDX_W+2]`.
- Each entry holds: `valid`, `tag`, `target[63:0]`, `jump` flag, `ctr[1:0]`.
- Lookup is combinational on `pc_cur`.
  - `hit = valid[idx] && tag match`.
  - `pred_taken = hit && (jump || ctr[1])`.
  - `pred_target = hit ? target : pc_cur+4`.
- Mispredict condition: `mis = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target))`.
- `npc` priority:
  1. If `mis`: `ex_taken ? ex_target : ex_pc+4`.
  2. Else if `pred_taken`: `pred_target`.
  3. Else: `pc_cur+4`.
- `flush = mis`.
- Update on the clock edge when `ex_valid`, at `ex_pc`'s index/tag:
  - Hit, conditional branch: `ctr` increments on taken (saturates at 3) and decrements on not-taken (saturates at 0). `target <= ex_target` if taken.
  - Hit, jump: `ctr <= 3`, `target <= ex_target`.
  - Miss and `ex_taken`: allocate, overwriting any occupant. `valid<=1`, `tag`, `target<=ex_target`, `jump<=ex_is_jump`, `ctr <= ex_is_jump ? 3 : 2`.
  - Miss and not taken: no change.
- `mispredict_count` increments on each `mis` cycle and saturates at 0xFFFF_FFFF.
- All PC arithmetic is modulo 2^64; `0xFFFF_FFFF_FFFF_FFFC + 4 = 0`.

## Timing
- Reset (async) clears all `valid` bits, sets all `ctr = 2'b01`, and clears `mispredict_count`.
- Outputs during/after reset:
  - `pred_taken = 0`, `flush = 0`.
  - `npc = pc_cur+4` (4 while PC is 0).
  - `pred_target = pc_cur+4`.
- Lookup and redirect are zero-latency, combinational in the same cycle.
- Table updates become visible in the cycle after the `ex_valid` edge.
- A same-cycle lookup and update to the same index: the lookup sees the pre-update contents.
- A redirect overrides any concurrent prediction.
- No dependence on PC stall: updates proceed regardless of the program counter's write enable. When PC is stalled, `npc` is simply not captured by the PC.
- Reset mid-operation: the table returns immediately to its reset state. An in-flight EX update in that cycle is discarded.

## Configuration
- `NPC_2BIT_CTR_EN` defined: conditional-branch direction comes from `ctr[1]` as described above.
- `NPC_2BIT_CTR_EN` undefined:
  - No `ctr` storage is implemented.
  - Every BTB hit predicts taken.
  - An entry is invalidated (`valid<=0`) when a hit conditional branch resolves not-taken.
  - Allocation and jump handling are unchanged.

## Test plan
- Reset, `pc_cur=0`, no EX activity: `npc=4`, `pred_taken=0`, `flush=0`, `mispredict_count=0`.
- Cold taken branch: `ex_valid=1`, `ex_pc=0x40`, `ex_taken=1`, `ex_target=0x100`, `ex_pred_taken=0`.
  - Same cycle: `flush=1`, `npc=0x100`, `mispredict_count` becomes 1.
  - Next cycle with `pc_cur=0x40`: `pred_taken=1`, `npc=0x100`.
- Counter hysteresis (macro defined): after allocation (`ctr=2`), one not-taken resolve at `0x40` gives `ctr=1`, so the lookup at `0x40` gives `npc=0x44`. Two taken resolves then give `ctr=3`.
- Aliasing, `ENTRIES=16`: allocate `0x40`, then a taken branch at `0x440` (same index, different tag) replaces it. The lookup at `0x40` then misses and gives `npc=0x44`.
- Wrong target on a predicted-taken JALR: `ex_pred_target=0x100`, `ex_target=0x200` gives `flush=1`, `npc=0x200`. The entry target becomes `0x200`.
- Wrap and saturation:
  - `pc_cur=0xFFFF_FFFF_FFFF_FFFC` with no hit gives `npc=0`.
  - Forcing 2^32 mispredicts holds `mispredict_count` at 0xFFFF_FFFF.
